// File: rtl/mips_core_pkg.sv
// Minimal slice of the core-wide package: only the branch outcome type that
// the perceptron weight sequencer consumes.
package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

endpackage

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron branch predictor weight store.
// Holds the array geometry, the weight/row/job types, the sequencer state
// encoding and the saturating weight update used by training.
package perceptron_pkg;

  import mips_core_pkg::*;

  localparam int PERCEPTRON_NUMBER = 1024;
  localparam int HISTORY_SIZE      = 62;
  // One bias weight plus one weight per history bit.
  localparam int WEIGHT_NUMBER     = HISTORY_SIZE + 1;
  localparam int WEIGHT_BITS       = 8;
  localparam int FIFO_DEPTH        = 4;
  localparam int STARVE_LIMIT      = 8;

  localparam int IDX_W      = $clog2(PERCEPTRON_NUMBER);
  localparam int ROW_W      = WEIGHT_NUMBER * WEIGHT_BITS;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W   = $clog2(STARVE_LIMIT + 1);

  typedef logic signed [WEIGHT_BITS-1:0] weight_t;
  // Weight k lives at bits [k*WEIGHT_BITS +: WEIGHT_BITS] of the flat row.
  typedef weight_t [WEIGHT_NUMBER-1:0]   weight_row_t;
  typedef logic [IDX_W-1:0]              row_idx_t;
  typedef logic [HISTORY_SIZE-1:0]       hist_t;

  typedef struct packed {
    row_idx_t     index;
    hist_t        hist;
    BranchOutcome outcome;
  } train_job_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD,
    WAIT,
    UPD,
    WR
  } seq_state_t;

  localparam weight_t WMAX = weight_t'((2 ** (WEIGHT_BITS - 1)) - 1);
  localparam weight_t WMIN = weight_t'(-(2 ** (WEIGHT_BITS - 1)));

  // One saturating +1/-1 step; pinned at the rails instead of wrapping.
  function automatic weight_t sat_step(input weight_t w, input logic inc);
    if (inc) begin
      return (w == WMAX) ? w : w + weight_t'(1);
    end
    return (w == WMIN) ? w : w - weight_t'(1);
  endfunction

  // Perceptron training: the bias follows the outcome, every other weight
  // moves towards agreement between the outcome and its history bit.
  function automatic weight_row_t sat_update(input weight_row_t row,
                                             input hist_t       hist,
                                             input BranchOutcome outcome);
    weight_row_t res;
    logic        t;
    t      = (outcome == TAKEN);
    res[0] = sat_step(row[0], t);
    for (int k = 1; k < WEIGHT_NUMBER; k++) begin
      res[k] = sat_step(row[k], t == hist[k-1]);
    end
    return res;
  endfunction

endpackage

// File: rtl/perceptron_train_fifo.sv
// Small synchronous FIFO of pending training jobs.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   push        write push_job when not full (ignored when full)
//   push_job    job to enqueue
//   pop         drop the head entry when not empty
//   head_job    current head entry (valid only when !empty)
//   full/empty  derived from the registered occupancy count
module perceptron_train_fifo
  import perceptron_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  train_job_t push_job,
  input  logic       pop,
  output train_job_t head_job,
  output logic       full,
  output logic       empty
);

  train_job_t            mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic [FIFO_CNT_W-1:0] count;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_job = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, and the count/pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_job;
  end

endmodule

// File: rtl/perceptron_weight_sequencer.sv
// Owner of the single-port perceptron weight SRAM.
// After reset it zero-fills every row, then arbitrates fetch-stage row reads
// against queued training jobs, each of which is a read-modify-write of one
// row with saturating weight arithmetic.
// Ports:
//   clk, rst_n                     clock / asynchronous active-low reset
//   i_pred_valid, i_pred_index     prediction row-read request
//   o_pred_ready                   prediction owns the port this cycle
//   o_pred_rvalid, o_pred_rdata    row data, one cycle after an accepted read
//   i_train_valid, o_train_ready   training job handshake
//   i_train_index/hist/outcome     training job payload
//   o_mem_en/we/addr/wdata         SRAM command
//   i_mem_rdata                    SRAM read data, one cycle latency
//   o_init_done                    zero-fill sweep has finished
module perceptron_weight_sequencer
  import perceptron_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_pred_valid,
  input  logic [IDX_W-1:0]             i_pred_index,
  output logic                         o_pred_ready,
  output logic                         o_pred_rvalid,
  output logic [ROW_W-1:0]             o_pred_rdata,
  input  logic                         i_train_valid,
  output logic                         o_train_ready,
  input  logic [IDX_W-1:0]             i_train_index,
  input  logic [HISTORY_SIZE-1:0]      i_train_hist,
  input  mips_core_pkg::BranchOutcome  i_train_outcome,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [IDX_W-1:0]             o_mem_addr,
  output logic [ROW_W-1:0]             o_mem_wdata,
  input  logic [ROW_W-1:0]             i_mem_rdata,
  output logic                         o_init_done
);

  seq_state_t            state_q;
  seq_state_t            state_d;
  logic                  active_q;     // low only in the first cycle out of reset
  row_idx_t              init_cnt_q;
  logic [STARVE_W-1:0]   starve_q;
  logic                  init_done_q;
  logic                  rvalid_q;
  weight_row_t           row_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  train_job_t            push_job;
  train_job_t            head_job;

  logic                  train_wants;
  logic                  force_train;
  logic                  pred_ready;
  logic                  pred_accept;
  logic                  train_grant;

  // ---------------------------------------------------------------------------
  // Training job queue
  // ---------------------------------------------------------------------------
  assign o_train_ready = init_done_q && !fifo_full;
  assign fifo_push     = i_train_valid && o_train_ready;
  assign push_job      = '{index: i_train_index, hist: i_train_hist, outcome: i_train_outcome};

  perceptron_train_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_job (push_job),
    .pop      (fifo_pop),
    .head_job (head_job),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Port arbitration. Predictions get the port unless training has been
  // starved STARVE_LIMIT times in a row; the ready flag never looks at
  // i_pred_valid, so it only depends on registered state.
  // ---------------------------------------------------------------------------
  assign train_wants = (state_q == RD) || (state_q == WR);
  assign force_train = train_wants && (starve_q == STARVE_W'(STARVE_LIMIT));
  assign pred_ready  = (state_q != INIT) && !force_train;
  assign pred_accept = pred_ready && i_pred_valid;
  assign train_grant = train_wants && !pred_accept;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      INIT: if (active_q && (init_cnt_q == row_idx_t'(PERCEPTRON_NUMBER - 1))) state_d = IDLE;
      IDLE: if (!fifo_empty) state_d = RD;
      RD:   if (train_grant) state_d = WAIT;
      WAIT: state_d = UPD;
      UPD:  state_d = WR;
      WR: begin
        if (train_grant) begin
          state_d  = IDLE;
          fifo_pop = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // SRAM command
  // ---------------------------------------------------------------------------
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state_q == INIT) begin
      // Held off while active_q is low so the port stays quiet in reset.
      o_mem_en   = active_q;
      o_mem_we   = active_q;
      o_mem_addr = init_cnt_q;
    end else if (pred_accept) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_pred_index;
    end else if (train_grant) begin
      o_mem_en   = 1'b1;
      o_mem_addr = head_job.index;
      if (state_q == WR) begin
        o_mem_we    = 1'b1;
        o_mem_wdata = row_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      active_q    <= 1'b0;
      init_cnt_q  <= '0;
      starve_q    <= '0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      rvalid_q <= pred_accept;
      if ((state_q == INIT) && active_q) init_cnt_q <= init_cnt_q + 1'b1;
      if ((state_q == INIT) && (state_d == IDLE)) init_done_q <= 1'b1;
      // Counts consecutive cycles training wanted the port and lost it.
      if (train_grant) begin
        starve_q <= '0;
      end else if (train_wants) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Row buffer for the read-modify-write; contents are meaningless outside a
  // job, so it carries no reset.
  always_ff @(posedge clk) begin
    case (state_q)
      WAIT:    row_q <= i_mem_rdata;
      UPD:     row_q <= sat_update(row_q, head_job.hist, head_job.outcome);
      default: row_q <= row_q;
    endcase
  end

  assign o_pred_ready  = pred_ready;
  assign o_pred_rvalid = rvalid_q;
  assign o_pred_rdata  = rvalid_q ? i_mem_rdata : '0;
  assign o_init_done   = init_done_q;

endmodule
